// File: rtl/jtopl_wrseq_pkg.sv
// -----------------------------------------------------------------------------
// jtopl_wrseq_pkg
// Shared types and constants for the JTOPL host write sequencer.
//   wrseq_state_e  : sequencer FSM states
//   REQ_W          : width of one queued request word {reg, val}
//   OPL_ADDR_WAIT  : default YM3812 post-address wait, in cen ticks
//   OPL_DATA_WAIT  : default YM3812 post-data wait, in cen ticks
//   max_int()      : elaboration-time helper used to size the wait counter
// -----------------------------------------------------------------------------
package jtopl_wrseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DWAIT = 3'd4
    } wrseq_state_e;

    localparam int REQ_W         = 16;
    localparam int OPL_ADDR_WAIT = 12;
    localparam int OPL_DATA_WAIT = 84;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/jtopl_wrseq_fifo.sv
// -----------------------------------------------------------------------------
// jtopl_wrseq_fifo
// Synchronous first-word-fall-through FIFO holding {reg, val} write requests.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write request (ignored when full or flushing)
//   pop, dout    : read request; dout always shows the oldest entry
//   flush        : drop every stored entry on this edge (wins over push/pop)
//   level        : current occupancy, 0 .. 2^DEPTH_LOG2
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module jtopl_wrseq_fifo
    import jtopl_wrseq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [REQ_W-1:0]      din,
    output logic [REQ_W-1:0]      dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    logic [REQ_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (level_r == LVL_W'(DEPTH));
    assign empty  = (level_r == LVL_W'(0));
    assign push_s = push && !full && !flush;
    assign pop_s  = pop && !empty && !flush;
    assign level  = level_r;
    assign dout   = mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_wrseq.sv
// -----------------------------------------------------------------------------
// jtopl_wrseq
// Host-side write sequencer for the JTOPL core. Queues (register, value)
// requests and replays each as an OPL address write followed by a data write,
// inserting the chip's post-address / post-data waits counted in cen ticks.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cen                   : OPL clock enable (same one the core uses)
//   req_valid/req_ready   : request handshake; req_reg/req_val are the payload
//   flush                 : drop queued requests (the one in flight finishes)
//   busy                  : queue not empty or a write sequence in progress
//   level                 : queue occupancy
//   opl_write/addr/dout   : one-clk write strobe, phase select, data bus
// Build option:
//   JTOPL_WRSEQ_ADDR_CACHE_EN : remember the last register addressed and skip
//                               the address phase when it is written again.
// -----------------------------------------------------------------------------
module jtopl_wrseq
    import jtopl_wrseq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WAIT  = OPL_ADDR_WAIT,
    parameter int DATA_WAIT  = OPL_DATA_WAIT
)(
    input  logic                  rst,
    input  logic                  clk,
    input  logic                  cen,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_reg,
    input  logic [7:0]            req_val,
    input  logic                  flush,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  opl_write,
    output logic                  opl_addr,
    output logic [7:0]            opl_dout
);

    localparam int CNT_W = $clog2(max_int(ADDR_WAIT, DATA_WAIT) + 1);
    localparam int LVL_W = DEPTH_LOG2 + 1;

    wrseq_state_e     state_r;
    wrseq_state_e     state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [7:0]       h_reg_r;
    logic [7:0]       h_reg_nx_s;
    logic [7:0]       h_val_r;
    logic [7:0]       h_val_nx_s;
    logic             settled_r;
    logic             push_s;
    logic             pop_s;
    logic             strobe_s;
    logic             cache_hit_s;
    logic [REQ_W-1:0] fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] level_nx_s;

    assign req_ready = !fifo_full_s && !flush;
    assign push_s    = req_valid && req_ready;

    jtopl_wrseq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush),
        .din   ({req_reg, req_val}),
        .dout  (fifo_dout_s),
        .level (level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef JTOPL_WRSEQ_ADDR_CACHE_EN
    logic [7:0] last_reg_r;
    logic       last_ok_r;

    // Remember the register latched by the most recent address strobe; flush keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg_r <= 8'h00;
            last_ok_r  <= 1'b0;
        end else if (state_r == ST_ADDR) begin
            last_reg_r <= h_reg_r;
            last_ok_r  <= 1'b1;
        end
    end

    assign cache_hit_s = last_ok_r && (fifo_dout_s[15:8] == last_reg_r);
`else
    assign cache_hit_s = 1'b0;
`endif

    // Sequencer next-state, wait counter and holding-register update.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        h_reg_nx_s = h_reg_r;
        h_val_nx_s = h_val_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // settled_r forces one full idle cycle between consecutive
                // write pairs; a flush in this cycle takes priority over a pop.
                if (!fifo_empty_s && settled_r && !flush) begin
                    pop_s      = 1'b1;
                    h_reg_nx_s = fifo_dout_s[15:8];
                    h_val_nx_s = fifo_dout_s[7:0];
                    if (cache_hit_s) begin
                        state_nx_s = ST_DATA;
                    end else begin
                        state_nx_s = ST_ADDR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // A cen landing on the strobe cycle is intentionally not counted.
                cnt_nx_s   = CNT_W'(ADDR_WAIT);
                state_nx_s = ST_AWAIT;
            end
            ST_AWAIT: begin
                if (cen && (cnt_r == CNT_W'(1))) begin
                    state_nx_s = ST_DATA;
                end else if (cen) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            ST_DATA: begin
                cnt_nx_s   = CNT_W'(DATA_WAIT);
                state_nx_s = ST_DWAIT;
            end
            ST_DWAIT: begin
                if (cen && (cnt_r == CNT_W'(1))) begin
                    state_nx_s = ST_IDLE;
                end else if (cen) begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this edge, used so busy can be registered without lag.
    always_comb begin
        level_nx_s = level;
        if (flush) begin
            level_nx_s = LVL_W'(0);
        end else if (push_s && !pop_s) begin
            level_nx_s = level + LVL_W'(1);
        end else if (!push_s && pop_s) begin
            level_nx_s = level - LVL_W'(1);
        end else begin
            level_nx_s = level;
        end
    end

    assign strobe_s = (state_nx_s == ST_ADDR) || (state_nx_s == ST_DATA);

    // State, counter, holding registers and registered OPL-side outputs.
    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_W'(0);
            h_reg_r   <= 8'h00;
            h_val_r   <= 8'h00;
            settled_r <= 1'b1;
            busy      <= 1'b0;
            opl_write <= 1'b0;
            opl_addr  <= 1'b0;
            opl_dout  <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            h_reg_r   <= h_reg_nx_s;
            h_val_r   <= h_val_nx_s;
            settled_r <= (state_r == ST_IDLE);
            busy      <= (level_nx_s != LVL_W'(0)) || (state_nx_s != ST_IDLE);
            opl_write <= strobe_s;
            if (state_nx_s == ST_ADDR) begin
                opl_addr <= 1'b0;
                opl_dout <= h_reg_nx_s;
            end else if (state_nx_s == ST_DATA) begin
                opl_addr <= 1'b1;
                opl_dout <= h_val_nx_s;
            end
        end
    end

endmodule
